// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_pkg
//  Description : Shared geometry constants and state/grant encodings for the
//                VGA text-memory write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

  localparam int COLS      = 160;          // 1280 / 8
  localparam int ROWS      = 64;           // 1024 / 16
  localparam int TEXT_SIZE = COLS * ROWS;  // 10240 characters

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_PEND = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RUN  = 2'd1,
    F_DONE = 2'd2
  } fill_state_t;

  // FILL encodes as 0 so a cleared register means "fill went last",
  // letting the CPU win the first tie out of reset.
  typedef enum logic {
    GNT_FILL = 1'b0,
    GNT_CPU  = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/vga_text_wr_arbiter_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : One-bit two-flop synchronizer into the pixel_clk domain,
//                cleared by the synchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic pixel_clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation of an asynchronous level
  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_text_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_wr_arbiter
//  Description : Owns the text-memory write port. Serves CPU character stores
//                and a fill engine (clear screen / clear line), both arriving
//                over 4-phase req/ack from another clock domain, with
//                round-robin arbitration and registered write outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_wr_arbiter #(
  parameter int ADDR_W = 15,
  parameter int COLS   = vga_text_pkg::COLS,
  parameter int ROWS   = vga_text_pkg::ROWS
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_char,
  output logic              cpu_ack,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [7:0]        fill_char,
  output logic              fill_ack,
  output logic              fill_err,
  output logic              busy,
  output logic [ADDR_W-1:0] vga_addr,
  output logic [7:0]        vga_data,
  output logic              vga_wen
);

  import vga_text_pkg::*;

  localparam logic [ADDR_W-1:0] c_text_size = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);

  logic              w_cpu_req_s;
  logic              w_fill_req_s;
  cpu_state_t        r_cpu_state;
  cpu_state_t        w_cpu_next;
  fill_state_t       r_fill_state;
  fill_state_t       w_fill_next;
  grant_t            r_last_grant;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_fill_char;
  logic              r_cpu_ack;
  logic              r_fill_ack;
  logic              r_fill_err;
  logic [ADDR_W-1:0] r_vga_addr;
  logic [7:0]        r_vga_data;
  logic              r_vga_wen;
  logic              w_cpu_rdy;
  logic              w_fill_rdy;
  logic              w_gnt_cpu;
  logic              w_gnt_fill;
  logic              w_fill_start;
  logic              w_base_bad;
  logic [ADDR_W-1:0] w_len_clamped;

  sync_2ff u_sync_cpu (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .i_d       (cpu_req),
    .o_q       (w_cpu_req_s)
  );

  sync_2ff u_sync_fill (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .i_d       (fill_req),
    .o_q       (w_fill_req_s)
  );

  // Round-robin grant: a lone requester always wins; on a tie the one that
  // did not go last is served.
  always_comb begin
    w_cpu_rdy  = (r_cpu_state == C_PEND);
    w_fill_rdy = (r_fill_state == F_RUN);
    w_gnt_cpu  = w_cpu_rdy && (!w_fill_rdy || (r_last_grant == GNT_FILL));
    w_gnt_fill = w_fill_rdy && !w_gnt_cpu;
  end

  // Fill request decode: range check on base and clamp of length
  always_comb begin
    w_fill_start  = w_fill_req_s && !r_fill_ack;
    w_base_bad    = (fill_base >= c_text_size);
    w_len_clamped = (fill_len > c_text_size) ? c_text_size : fill_len;
  end

  // State registers for both requester FSMs
  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_cpu_state  <= C_IDLE;
      r_fill_state <= F_IDLE;
    end else begin
      r_cpu_state  <= w_cpu_next;
      r_fill_state <= w_fill_next;
    end
  end

  // CPU handshake next-state logic
  always_comb begin
    w_cpu_next = r_cpu_state;
    case (r_cpu_state)
      C_IDLE:  if (w_cpu_req_s && !r_cpu_ack) w_cpu_next = C_PEND;
      C_PEND:  if (w_gnt_cpu) w_cpu_next = C_ACK;
      C_ACK:   if (!w_cpu_req_s) w_cpu_next = C_IDLE;
      default: w_cpu_next = C_IDLE;
    endcase
  end

  // Fill engine next-state logic
  always_comb begin
    w_fill_next = r_fill_state;
    case (r_fill_state)
      F_IDLE:  if (w_fill_start)
                 w_fill_next = (w_base_bad || (fill_len == '0)) ? F_DONE : F_RUN;
      F_RUN:   if (w_gnt_fill && (r_cnt == c_one)) w_fill_next = F_DONE;
      F_DONE:  if (!w_fill_req_s) w_fill_next = F_IDLE;
      default: w_fill_next = F_IDLE;
    endcase
  end

  // CPU ack is held one cycle behind C_ACK and dropped once req is seen low
  always_ff @(posedge pixel_clk) begin
    if (!rst) r_cpu_ack <= 1'b0;
    else      r_cpu_ack <= (r_cpu_state == C_ACK) && w_cpu_req_s;
  end

  // Fill datapath: latch the job, step pointer/count per granted write
  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_fill_char <= 8'h00;
      r_fill_ack  <= 1'b0;
      r_fill_err  <= 1'b0;
    end else begin
      case (r_fill_state)
        F_IDLE: if (w_fill_start) begin
          r_ptr       <= fill_base;
          r_cnt       <= w_len_clamped;
          r_fill_char <= fill_char;
          r_fill_err  <= w_base_bad;
        end
        F_RUN: if (w_gnt_fill) begin
          r_ptr <= (r_ptr == c_last_addr) ? '0 : r_ptr + c_one;
          r_cnt <= r_cnt - c_one;
        end
        F_DONE: begin
          r_fill_ack <= w_fill_req_s;
          if (!w_fill_req_s) r_fill_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registered write port and round-robin history
  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_vga_wen    <= 1'b0;
      r_vga_addr   <= '0;
      r_vga_data   <= 8'h00;
      r_last_grant <= GNT_FILL;
    end else begin
      r_vga_wen <= w_gnt_cpu || w_gnt_fill;
      if (w_gnt_cpu) begin
        r_vga_addr   <= cpu_addr;
        r_vga_data   <= cpu_char;
        r_last_grant <= GNT_CPU;
      end else if (w_gnt_fill) begin
        r_vga_addr   <= r_ptr;
        r_vga_data   <= r_fill_char;
        r_last_grant <= GNT_FILL;
      end
    end
  end

  assign cpu_ack  = r_cpu_ack;
  assign fill_ack = r_fill_ack;
  assign fill_err = r_fill_err;
  assign busy     = (r_fill_state == F_RUN);
  assign vga_addr = r_vga_addr;
  assign vga_data = r_vga_data;
  assign vga_wen  = r_vga_wen;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_text_wr_arbiter
//  Description : Scoreboard bench for vga_text_wr_arbiter. Stimulus pushes the
//                expected writes; a monitor pops and compares on each vga_wen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_wr_arbiter;
  import vga_text_pkg::*;

  localparam int ADDR_W = 15;

  logic              pixel_clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_char = 8'h00;
  logic              cpu_ack;
  logic              fill_req = 1'b0;
  logic [ADDR_W-1:0] fill_base = '0;
  logic [ADDR_W-1:0] fill_len = '0;
  logic [7:0]        fill_char = 8'h00;
  logic              fill_ack;
  logic              fill_err;
  logic              busy;
  logic [ADDR_W-1:0] vga_addr;
  logic [7:0]        vga_data;
  logic              vga_wen;

  vga_text_wr_arbiter #(.ADDR_W(ADDR_W), .COLS(COLS), .ROWS(ROWS)) dut (
    .pixel_clk (pixel_clk), .rst (rst),
    .cpu_req (cpu_req), .cpu_addr (cpu_addr), .cpu_char (cpu_char), .cpu_ack (cpu_ack),
    .fill_req (fill_req), .fill_base (fill_base), .fill_len (fill_len),
    .fill_char (fill_char), .fill_ack (fill_ack), .fill_err (fill_err), .busy (busy),
    .vga_addr (vga_addr), .vga_data (vga_data), .vga_wen (vga_wen)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int busy_cycles = 0;
  int last_wen_cyc = -10;
  int cpu_wr_cyc = -1;
  int ack_cyc = 0;
  logic [22:0] fill_q[$];
  logic [22:0] cpu_q[$];

  always @(posedge pixel_clk) cyc++;

  // Monitor: every write must match the head of the CPU or fill queue
  always @(negedge pixel_clk) begin
    logic [22:0] exp;
    if (busy === 1'b1) busy_cycles++;
    if (vga_wen === 1'b1) begin
      wr_count++;
      last_wen_cyc = cyc;
      if (cpu_q.size() > 0 && {vga_addr, vga_data} == cpu_q[0]) begin
        checks++;
        void'(cpu_q.pop_front());
        cpu_wr_cyc = cyc;
      end else if (fill_q.size() > 0) begin
        exp = fill_q.pop_front();
        checks++;
        if ({vga_addr, vga_data} !== exp) begin
          errors++;
          $display("FAIL fill_write got addr=%0d data=%h want addr=%0d data=%h",
                   vga_addr, vga_data, exp[22:8], exp[7:0]);
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h want no write", vga_addr, vga_data);
      end
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_fill_ack(input logic lvl, input int budget);
    int n = 0;
    while (fill_ack !== lvl && n < budget) begin
      tick();
      n++;
    end
    ack_cyc = cyc;
    check(lvl ? "fill_ack_rise" : "fill_ack_fall", {31'd0, fill_ack}, {31'd0, lvl});
  endtask

  task automatic wait_cpu_ack(input logic lvl, input int budget);
    int n = 0;
    while (cpu_ack !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(lvl ? "cpu_ack_rise" : "cpu_ack_fall", {31'd0, cpu_ack}, {31'd0, lvl});
  endtask

  task automatic push_fill(input int base, input int len, input logic [7:0] ch);
    logic [14:0] a;
    for (int i = 0; i < len; i++) begin
      a = 15'((base + i) % TEXT_SIZE);
      fill_q.push_back({a, ch});
    end
  endtask

  // One complete fill handshake with its expected write stream
  task automatic do_fill(input int base, input int len, input logic [7:0] ch,
                         input logic exp_err, input int exp_wr);
    int w0;
    w0 = wr_count;
    busy_cycles = 0;
    push_fill(base, exp_wr, ch);
    fill_base = base[14:0];
    fill_len  = len[14:0];
    fill_char = ch;
    fill_req  = 1'b1;
    wait_fill_ack(1'b1, exp_wr + 40);
    check("fill_err", {31'd0, fill_err}, {31'd0, exp_err});
    check("fill_writes", wr_count - w0, exp_wr);
    check("fill_busy_cycles", busy_cycles, exp_wr);
    if (exp_wr > 0) check("fill_ack_after_last_wen", last_wen_cyc, ack_cyc - 1);
    fill_req = 1'b0;
    wait_fill_ack(1'b0, 10);
    check("fill_err_cleared", {31'd0, fill_err}, 32'd0);
    tick();
  endtask

  initial begin
    int w0;
    int n;
    int req_cyc;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {vga_wen, vga_addr, vga_data, cpu_ack, fill_ack, fill_err, busy}, 32'd0);
    rst = 1'b1;
    tick();

    // CPU write alone, cycle-exact latency
    cpu_addr = 15'h0123;
    cpu_char = 8'h41;
    cpu_q.push_back({15'h0123, 8'h41});
    cpu_req = 1'b1;
    repeat (3) tick();
    check("cpu_wen_not_yet", {31'd0, vga_wen}, 32'd0);
    tick();
    check("cpu_wen_edge4", {31'd0, vga_wen}, 32'd1);
    check("cpu_addr", {17'd0, vga_addr}, 32'h0123);
    check("cpu_data", {24'd0, vga_data}, 32'h41);
    tick();
    check("cpu_ack_edge5", {31'd0, cpu_ack}, 32'd1);
    check("cpu_wen_single", {31'd0, vga_wen}, 32'd0);
    cpu_req = 1'b0;
    repeat (2) tick();
    check("cpu_ack_held", {31'd0, cpu_ack}, 32'd1);
    tick();
    check("cpu_ack_drop_edge3", {31'd0, cpu_ack}, 32'd0);
    repeat (2) tick();

    // Fill alone, wrap, clamp, out-of-range base, zero length
    do_fill(10, 5, 8'h20, 1'b0, 5);
    do_fill(10238, 4, 8'h2A, 1'b0, 4);
    do_fill(0, 20000, 8'h00, 1'b0, TEXT_SIZE);
    do_fill(10240, 3, 8'h31, 1'b1, 0);
    do_fill(7, 0, 8'h32, 1'b0, 0);

    // Contention: CPU store in the middle of a 100-character fill
    w0 = wr_count;
    busy_cycles = 0;
    push_fill(0, 100, 8'h2E);
    fill_base = 15'd0;
    fill_len  = 15'd100;
    fill_char = 8'h2E;
    fill_req  = 1'b1;
    n = 0;
    while (wr_count - w0 < 20 && n < 200) begin
      tick();
      n++;
    end
    cpu_addr = 15'h7FFF;
    cpu_char = 8'h55;
    cpu_q.push_back({15'h7FFF, 8'h55});
    cpu_wr_cyc = -1;
    req_cyc = cyc;
    cpu_req = 1'b1;
    wait_cpu_ack(1'b1, 20);
    check("cpu_grant_latency", {31'd0, (cpu_wr_cyc >= 0) && (cpu_wr_cyc - req_cyc <= 5)}, 32'd1);
    cpu_req = 1'b0;
    wait_cpu_ack(1'b0, 10);
    wait_fill_ack(1'b1, 300);
    check("contention_writes", wr_count - w0, 101);
    check("contention_busy_cycles", busy_cycles, 101);
    fill_req = 1'b0;
    wait_fill_ack(1'b0, 10);
    tick();

    // Reset at write 50 of a 100-character fill, request held through reset
    w0 = wr_count;
    push_fill(200, 100, 8'h23);
    fill_base = 15'd200;
    fill_len  = 15'd100;
    fill_char = 8'h23;
    fill_req  = 1'b1;
    n = 0;
    while (wr_count - w0 < 50 && n < 200) begin
      @(negedge pixel_clk);
      #1;
      n++;
    end
    check("writes_before_reset", wr_count - w0, 50);
    rst = 1'b0;
    tick();
    check("outputs_after_reset", {vga_wen, vga_addr, vga_data, cpu_ack, fill_ack, fill_err, busy}, 32'd0);
    fill_q.delete();
    push_fill(200, 100, 8'h23);
    w0 = wr_count;
    rst = 1'b1;
    wait_fill_ack(1'b1, 200);
    check("refill_writes", wr_count - w0, 100);
    fill_req = 1'b0;
    wait_fill_ack(1'b0, 10);
    repeat (3) tick();

    check("cpu_queue_drained", cpu_q.size(), 0);
    check("fill_queue_drained", fill_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
